// File: rtl/step_scheduler_if.sv
// Handshake and configuration bundle between the game engine and the step scheduler.
// The engine side drives ticks, configuration and acks; the scheduler drives requests and statistics.
interface step_scheduler_if #(
    parameter int PW = 16,
    parameter int MW = 8,
    parameter int SW = 16
);
    logic          tick_1ms;
    logic          cfg_we;
    logic [PW-1:0] period_in;
    logic          run;
    logic          step_ack;
    logic          clr_stat;
    logic          step_req;
    logic [SW-1:0] step_seq;
    logic [MW-1:0] missed_cnt;
    logic          overrun;
    logic [1:0]    state;

    modport master (
        output tick_1ms, cfg_we, period_in, run, step_ack, clr_stat,
        input  step_req, step_seq, missed_cnt, overrun, state
    );

    modport slave (
        input  tick_1ms, cfg_we, period_in, run, step_ack, clr_stat,
        output step_req, step_seq, missed_cnt, overrun, state
    );
endinterface

// File: rtl/step_scheduler.sv
// Game-step scheduler: turns 1 ms ticks into step requests every period_reg ms,
// retired by req/ack; expiries that land on an outstanding request are counted as misses.
module step_scheduler #(
    parameter int PW         = 16,
    parameter int MW         = 8,
    parameter int SW         = 16,
    parameter int DEF_PERIOD = 200
) (
    input  logic mclk,
    input  logic clr_n,
    step_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_RUN  = 2'b01,
        ST_PEND = 2'b10
    } state_t;

    logic [PW-1:0] r_period;
    logic [PW-1:0] r_ms_cnt;
    logic          r_step_req;
    logic [SW-1:0] r_step_seq;
    logic [MW-1:0] r_missed;
    logic          r_overrun;
    state_t        r_state;

    logic          w_tick;
    logic          w_expire;
    logic          w_ack_fire;
    logic          w_issue;
    logic          w_miss;
    logic          w_req_next;
    logic          w_missed_sat;
    logic [PW-1:0] w_period_load;

    // A configuration write owns the cycle, so a coincident tick never advances the counter.
    // The >= compare keeps a shrunken period from skipping its expiry.
    assign w_tick        = bus.run & ~bus.cfg_we & bus.tick_1ms;
    assign w_expire      = w_tick & (r_ms_cnt >= (r_period - PW'(1)));
    assign w_ack_fire    = r_step_req & bus.step_ack;
    assign w_issue       = w_expire & (~r_step_req | w_ack_fire);
    assign w_miss        = w_expire & r_step_req & ~w_ack_fire;
    assign w_req_next    = w_issue | (r_step_req & ~w_ack_fire);
    assign w_missed_sat  = (r_missed == {MW{1'b1}});
    assign w_period_load = (bus.period_in == '0) ? PW'(1) : bus.period_in;

    always_ff @(posedge mclk or negedge clr_n) begin
        if (!clr_n) begin
            r_period   <= PW'(DEF_PERIOD);
            r_ms_cnt   <= '0;
            r_step_req <= 1'b0;
            r_step_seq <= '0;
            r_missed   <= '0;
            r_overrun  <= 1'b0;
            r_state    <= ST_STOP;
        end else begin
            if (bus.cfg_we) begin
                r_period <= w_period_load;
                r_ms_cnt <= '0;
            end else if (w_tick) begin
                r_ms_cnt <= w_expire ? '0 : (r_ms_cnt + PW'(1));
            end

            r_step_req <= w_req_next;
            if (w_issue) begin
                r_step_seq <= r_step_seq + SW'(1);
            end

            // A miss in the same cycle as a statistics clear leaves exactly one recorded miss.
            if (w_miss) begin
                if (bus.clr_stat) begin
                    r_missed <= MW'(1);
                end else if (!w_missed_sat) begin
                    r_missed <= r_missed + MW'(1);
                end
                r_overrun <= 1'b1;
            end else if (bus.clr_stat) begin
                r_missed  <= '0;
                r_overrun <= 1'b0;
            end

            if (w_req_next) begin
                r_state <= ST_PEND;
            end else if (bus.run) begin
                r_state <= ST_RUN;
            end else begin
                r_state <= ST_STOP;
            end
        end
    end

    assign bus.step_req   = r_step_req;
    assign bus.step_seq   = r_step_seq;
    assign bus.missed_cnt = r_missed;
    assign bus.overrun    = r_overrun;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_step_scheduler.sv
// Self-checking bench for step_scheduler: directed vector table, hand-written corner sequences
// and randomized traffic compared against a millisecond-level reference model.
module tb_step_scheduler;

    localparam int PW = 16;
    localparam int MW = 8;
    localparam int SW = 16;

    logic mclk;
    logic clr_n;

    step_scheduler_if #(.PW(PW), .MW(MW), .SW(SW)) bus ();

    step_scheduler #(.PW(PW), .MW(MW), .SW(SW), .DEF_PERIOD(200)) dut (
        .mclk  (mclk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    int nChecks = 0;
    int nFail   = 0;

    // Reference model state: elapsed ms in the current period, pending flag and statistics.
    int m_period, m_cnt, m_seq, m_missed, m_state;
    bit m_req, m_over;

    typedef struct {
        bit tick; bit cfg; int pin; bit run; bit ack; bit clr;
        bit eReq; int eSeq; int eMiss; bit eOver; int eState;
    } vec_t;

    vec_t vecs[19];

    task automatic modelReset();
        m_period = 200; m_cnt = 0; m_seq = 0; m_missed = 0; m_state = 0;
        m_req = 1'b0; m_over = 1'b0;
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input int exp);
        nChecks++;
        if (act !== 32'(exp)) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name);
        checkVal({name, "_req"},   32'(bus.step_req),   int'(m_req));
        checkVal({name, "_seq"},   32'(bus.step_seq),   m_seq);
        checkVal({name, "_miss"},  32'(bus.missed_cnt), m_missed);
        checkVal({name, "_over"},  32'(bus.overrun),    int'(m_over));
        checkVal({name, "_state"}, 32'(bus.state),      m_state);
    endtask

    // Drives one cycle of inputs, advances the model by the same cycle, and returns #1 after the edge.
    task automatic applyStimulus(input bit tick, input bit cfg, input int pin,
                                 input bit run, input bit ack, input bit clr);
        bit expired;
        bit fire;
        bus.tick_1ms  = tick;
        bus.cfg_we    = cfg;
        bus.period_in = 16'(pin);
        bus.run       = run;
        bus.step_ack  = ack;
        bus.clr_stat  = clr;

        expired = 1'b0;
        fire    = m_req && ack;
        if (cfg) begin
            m_period = (pin == 0) ? 1 : pin;
            m_cnt    = 0;
        end else if (run && tick) begin
            if (m_cnt + 1 >= m_period) begin
                m_cnt   = 0;
                expired = 1'b1;
            end else begin
                m_cnt++;
            end
        end
        if (clr) begin
            m_missed = 0;
            m_over   = 1'b0;
        end
        if (expired && m_req && !fire) begin
            m_missed = (m_missed + 1 > 255) ? 255 : m_missed + 1;
            m_over   = 1'b1;
        end else if (expired) begin
            m_req = 1'b1;
            m_seq = (m_seq + 1) % 65536;
        end else if (fire) begin
            m_req = 1'b0;
        end
        m_state = m_req ? 2 : (run ? 1 : 0);

        @(posedge mclk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{0,1,2,1,0,0, 0,0,0,0,1};
        vecs[1]  = '{1,0,0,1,0,0, 0,0,0,0,1};
        vecs[2]  = '{1,0,0,1,0,0, 1,1,0,0,2};
        vecs[3]  = '{0,0,0,1,0,0, 1,1,0,0,2};
        vecs[4]  = '{1,0,0,1,0,0, 1,1,0,0,2};
        vecs[5]  = '{1,0,0,1,0,0, 1,1,1,1,2};
        vecs[6]  = '{0,0,0,1,1,0, 0,1,1,1,1};
        vecs[7]  = '{1,0,0,1,1,0, 0,1,1,1,1};
        vecs[8]  = '{1,0,0,1,0,0, 1,2,1,1,2};
        vecs[9]  = '{1,0,0,1,0,0, 1,2,1,1,2};
        vecs[10] = '{1,0,0,1,1,0, 1,3,1,1,2};
        vecs[11] = '{0,0,0,1,0,1, 1,3,0,0,2};
        vecs[12] = '{1,0,0,0,0,0, 1,3,0,0,2};
        vecs[13] = '{0,0,0,0,1,0, 0,3,0,0,0};
        vecs[14] = '{1,1,0,1,0,0, 0,3,0,0,1};
        vecs[15] = '{1,0,0,1,0,0, 1,4,0,0,2};
        vecs[16] = '{1,0,0,1,0,0, 1,4,1,1,2};
        vecs[17] = '{1,0,0,1,0,1, 1,4,1,1,2};
        vecs[18] = '{1,0,0,1,0,0, 1,4,2,1,2};

        clr_n         = 1'b0;
        bus.tick_1ms  = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.period_in = '0;
        bus.run       = 1'b0;
        bus.step_ack  = 1'b0;
        bus.clr_stat  = 1'b0;
        modelReset();
        #12;
        checkVal("reset_req",   32'(bus.step_req),   0);
        checkVal("reset_seq",   32'(bus.step_seq),   0);
        checkVal("reset_miss",  32'(bus.missed_cnt), 0);
        checkVal("reset_over",  32'(bus.overrun),    0);
        checkVal("reset_state", 32'(bus.state),      0);
        #6 clr_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].tick, vecs[i].cfg, vecs[i].pin, vecs[i].run, vecs[i].ack, vecs[i].clr);
            checkVal($sformatf("vec%0d_req", i),   32'(bus.step_req),   int'(vecs[i].eReq));
            checkVal($sformatf("vec%0d_seq", i),   32'(bus.step_seq),   vecs[i].eSeq);
            checkVal($sformatf("vec%0d_miss", i),  32'(bus.missed_cnt), vecs[i].eMiss);
            checkVal($sformatf("vec%0d_over", i),  32'(bus.overrun),    int'(vecs[i].eOver));
            checkVal($sformatf("vec%0d_state", i), 32'(bus.state),      vecs[i].eState);
        end

        // Saturation with period 1 and a request that is never acknowledged.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1, 0, 0, 1, 0, 0);
            checkOutput("sat_run");
        end
        checkVal("sat_cap", 32'(bus.missed_cnt), 255);
        applyStimulus(0, 0, 0, 1, 0, 1);
        checkVal("sat_clear", 32'(bus.missed_cnt), 0);
        checkVal("sat_clear_over", 32'(bus.overrun), 0);
        applyStimulus(1, 0, 0, 1, 0, 1);
        checkVal("clr_vs_miss_cnt", 32'(bus.missed_cnt), 1);
        checkVal("clr_vs_miss_over", 32'(bus.overrun), 1);

        // Pause: period 5, three ticks, ten paused ticks, then two more ticks.
        applyStimulus(0, 0, 0, 1, 1, 0);
        checkVal("drop_req", 32'(bus.step_req), 0);
        applyStimulus(0, 1, 5, 1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0);
            checkOutput("paused");
        end
        checkVal("paused_state", 32'(bus.state), 0);
        applyStimulus(1, 0, 0, 1, 0, 0);
        checkVal("pause_tick4_req", 32'(bus.step_req), 0);
        applyStimulus(1, 0, 0, 1, 0, 0);
        checkVal("pause_tick5_req", 32'(bus.step_req), 1);
        checkVal("pause_tick5_seq", 32'(bus.step_seq), 5);

        // A tick coincident with a configuration write must not count.
        applyStimulus(0, 0, 0, 1, 1, 0);
        applyStimulus(1, 1, 3, 1, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0);
        checkVal("cfg_tick_ignored", 32'(bus.step_req), 0);
        applyStimulus(1, 0, 0, 1, 0, 0);
        checkVal("cfg_tick_third", 32'(bus.step_req), 1);
        checkVal("cfg_tick_seq", 32'(bus.step_seq), 6);

        // Asynchronous reset between edges while a request is pending.
        bus.tick_1ms = 1'b0;
        bus.run      = 1'b0;
        #1 clr_n = 1'b0;
        #1;
        checkVal("async_req",   32'(bus.step_req),   0);
        checkVal("async_seq",   32'(bus.step_seq),   0);
        checkVal("async_miss",  32'(bus.missed_cnt), 0);
        checkVal("async_over",  32'(bus.overrun),    0);
        checkVal("async_state", 32'(bus.state),      0);
        #10 clr_n = 1'b1;
        modelReset();

        // Default period after reset is 200 ms.
        for (int i = 0; i < 199; i++) applyStimulus(1, 0, 0, 1, 0, 0);
        checkVal("def_period_199", 32'(bus.step_req), 0);
        applyStimulus(1, 0, 0, 1, 0, 0);
        checkVal("def_period_200", 32'(bus.step_req), 1);
        checkVal("def_period_seq", 32'(bus.step_seq), 1);

        for (int i = 0; i < 2000; i++) begin
            applyStimulus($urandom_range(0, 1) == 1,
                          $urandom_range(0, 31) == 0,
                          int'($urandom_range(0, 6)),
                          $urandom_range(0, 7) != 0,
                          $urandom_range(0, 2) == 0,
                          $urandom_range(0, 15) == 0);
            checkOutput("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
